// File: rtl/uart_code_loader_pkg.sv
// Shared types for the UART code loader: loader FSM states, receiver
// states and the bit-period helper.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_code_loader_if.sv
// Code memory write port: the loader drives it, the memory consumes it.
interface uart_code_loader_if #(parameter int ADDR_W = 10);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_code_loader_rx.sv
// uart_rx: 8N1 byte receiver. rxd is synchronized through two flops, the
// start bit is confirmed at its middle, and every later bit is sampled one
// bit period after the previous sample. rx_valid / rx_ferr are one-cycle
// pulses on the stop-bit sample cycle; rx_byte holds the shifted byte.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a low level
// RX_START | half-bit wait, then confirm start bit (high = glitch)
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit (low = framing error)
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic [7:0] rx_byte
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q, sync_d;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxd_s;

  assign rxd_s   = sync_q[1];
  assign rx_byte = shift_q;

  // Register stage: synchronizer, receiver state, bit timer and shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: down-counting bit timer, sample on terminal count.
  always_comb begin
    sync_d    = {sync_q[0], rxd};
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_valid  = 1'b0;
    rx_ferr   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d = RX_START;
          timer_d = T_HALF;
        end
      end
      RX_START: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (!rxd_s) begin
          state_d   = RX_DATA;
          timer_d   = T_FULL;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d = {rxd_s, shift_q[7:1]};
          timer_d = T_FULL;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          rx_valid = rxd_s;
          rx_ferr  = !rxd_s;
          state_d  = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_code_loader.sv
// uart_code_loader: receives LEN_LO, LEN_HI and N payload bytes over UART
// and writes them to code memory addresses 0..N-1, holding the CPU in reset
// until the image is complete. Build option LOADER_CHECKSUM_EN adds a
// trailing 8-bit sum byte that must match the payload.
//
// state    | meaning
// S_LEN_LO | waiting for length low byte
// S_LEN_HI | waiting for length high byte, bound check
// S_DATA   | writing payload bytes, counting down remaining
// S_CSUM   | waiting for checksum byte (LOADER_CHECKSUM_EN only)
// S_DONE   | image loaded, CPU released, traffic ignored
// S_ERR    | framing/length/checksum error, CPU held until rst
module uart_code_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  uart_code_loader_if.master  mem,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int CLKS_PER_BIT = int'(clks_per_bit(CLK_FREQ, BAUD));
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  logic              rx_valid, rx_ferr;
  logic [7:0]        rx_byte;
  logic [15:0]       len_w;

  load_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_byte  (rx_byte)
  );

  assign len_w         = {rx_byte, len_lo_q};
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign load_done     = (state_q == S_DONE);
  assign load_err      = (state_q == S_ERR);

  // Register stage: FSM state, length/index counters and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LEN_LO;
      len_lo_q    <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Loader FSM: consumes received bytes, issues one write per payload byte.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_LEN_LO: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          len_lo_d = rx_byte;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          idx_d = '0;
          rem_d = len_w[ADDR_W:0];
          if ({1'b0, len_w} > MAX_LEN) begin
            state_d = S_ERR;
          end else if (len_w == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = rx_byte;
          rem_d       = rem_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + rx_byte;
`endif
          // Final byte: leave without advancing so the index never wraps.
          if (rem_q == (ADDR_W + 1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          state_d = (rx_byte == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

endmodule
